// File: rtl/fixed_point_abs_accumulator.sv
// L1-norm accumulator: sums VECTOR_LEN absolute values per START into a saturated sum.
// Optional build macro FIXED_POINT_ABS_ACC_MAX_EN adds MAX_OUT (largest addend of the run).
module fixed_point_abs_accumulator #(
    parameter int WIDTH      = 8,
    parameter int FRAC_BITS  = 4,
    parameter int VECTOR_LEN = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic [WIDTH-1:0] VALUE_IN,
    input  logic             VALID_IN,
    input  logic             OVERFLOW_IN,
    output logic [WIDTH-1:0] SUM_OUT,
    output logic             VALID_OUT,
    output logic             OVERFLOW_OUT,
`ifdef FIXED_POINT_ABS_ACC_MAX_EN
    output logic [WIDTH-1:0] MAX_OUT,
`endif
    output logic             BUSY
);
    // state | meaning
    // IDLE  | waiting for START, samples ignored
    // ACCUM | accepting samples until VECTOR_LEN have arrived
    // DONE  | VALID_OUT pulse cycle, then back to IDLE
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam int CW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam logic [CW-1:0]    LAST   = CW'(VECTOR_LEN - 1);
    localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] addend;
    logic             addend_sub;
    logic [WIDTH:0]   sum_ext;

    // Negative input can only come from the ABS stage wrapping the most-negative operand.
    assign addend_sub = OVERFLOW_IN | VALUE_IN[WIDTH-1];
    assign addend     = addend_sub ? MAXPOS : VALUE_IN;
    assign sum_ext    = {1'b0, sum_q} + {1'b0, addend};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        max_d   = max_q;
        if (START) begin
            state_d = ACCUM;
            count_d = '0;
            sum_d   = '0;
            ovf_d   = 1'b0;
            max_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (VALID_IN) begin
                        if (addend_sub) ovf_d = 1'b1;
                        if (sum_ext > {1'b0, MAXPOS}) begin
                            sum_d = MAXPOS;
                            ovf_d = 1'b1;
                        end else begin
                            sum_d = sum_ext[WIDTH-1:0];
                        end
                        if (addend > max_q) max_d = addend;
                        if (count_q == LAST) begin
                            state_d = DONE;
                            valid_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            count_q <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            max_q   <= max_d;
        end
    end

    assign SUM_OUT      = sum_q;
    assign VALID_OUT    = valid_q;
    assign OVERFLOW_OUT = ovf_q;
    assign BUSY         = (state_q == ACCUM);
`ifdef FIXED_POINT_ABS_ACC_MAX_EN
    assign MAX_OUT      = max_q;
`else
    logic unused_max;
    assign unused_max   = ^max_q;
`endif

endmodule

// File: tb/tb_fixed_point_abs_accumulator.sv
// Scoreboard bench: expected {sum, overflow} pushed at stimulus time, popped on VALID_OUT.
module tb_fixed_point_abs_accumulator;
    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       START = 1'b0;
    logic [7:0] VALUE_IN = '0;
    logic       VALID_IN = 1'b0;
    logic       OVERFLOW_IN = 1'b0;
    logic [7:0] SUM_OUT;
    logic       VALID_OUT;
    logic       OVERFLOW_OUT;
    logic       BUSY;
`ifdef FIXED_POINT_ABS_ACC_MAX_EN
    logic [7:0] MAX_OUT;
`endif

    fixed_point_abs_accumulator #(.WIDTH(8), .FRAC_BITS(4), .VECTOR_LEN(4)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .VALUE_IN(VALUE_IN),
        .VALID_IN(VALID_IN), .OVERFLOW_IN(OVERFLOW_IN), .SUM_OUT(SUM_OUT),
        .VALID_OUT(VALID_OUT), .OVERFLOW_OUT(OVERFLOW_OUT),
`ifdef FIXED_POINT_ABS_ACC_MAX_EN
        .MAX_OUT(MAX_OUT),
`endif
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;
    int n_pulse = 0;
    int n_exp = 0;
    int exp_sum_q[$];
    int exp_ovf_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic expect_run(input int s, input int o);
        exp_sum_q.push_back(s);
        exp_ovf_q.push_back(o);
        n_exp++;
    endtask

    // one clock of stimulus; returns at posedge+1 with inputs cleared
    task automatic cyc(input logic st, input logic v, input logic [7:0] val, input logic ov);
        START = st; VALID_IN = v; VALUE_IN = val; OVERFLOW_IN = ov;
        @(posedge CLK); #1;
        START = 1'b0; VALID_IN = 1'b0; VALUE_IN = '0; OVERFLOW_IN = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while (exp_sum_q.size() != 0 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("drain_timeout", exp_sum_q.size(), 0);
    endtask

    always @(negedge CLK) begin
        if (VALID_OUT === 1'b1) begin
            n_pulse++;
            if (exp_sum_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                chk("sum_out", int'(SUM_OUT), exp_sum_q.pop_front());
                chk("ovf_out", int'(OVERFLOW_OUT), exp_ovf_q.pop_front());
                chk("busy_at_valid", int'(BUSY), 0);
            end
        end
    end

    initial begin
        #2;
        chk("rst_sum", int'(SUM_OUT), 0);
        chk("rst_valid", int'(VALID_OUT), 0);
        chk("rst_ovf", int'(OVERFLOW_OUT), 0);
        chk("rst_busy", int'(BUSY), 0);
        @(posedge CLK); #1;
        RSTN = 1'b1;
        @(posedge CLK); #1;

        // basic run
        cyc(1, 0, 0, 0);
        chk("busy_accum", int'(BUSY), 1);
        expect_run(24, 0);
        cyc(0, 1, 3, 0); cyc(0, 1, 5, 0); cyc(0, 1, 7, 0); cyc(0, 1, 9, 0);
        chk("valid_latency", int'(VALID_OUT), 1);
        cyc(0, 0, 0, 0);
        chk("valid_one_cycle", int'(VALID_OUT), 0);
        chk("hold_sum", int'(SUM_OUT), 24);
        drain();

        // saturation on the add
        cyc(1, 0, 0, 0);
        expect_run(127, 1);
        cyc(0, 1, 100, 0); cyc(0, 1, 50, 0);
        chk("sat_after2", int'(SUM_OUT), 127);
        chk("sat_ovf_after2", int'(OVERFLOW_OUT), 1);
        cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
        drain();

        // ABS-stage overflow substitution
        cyc(1, 0, 0, 0);
        chk("start_clears_ovf", int'(OVERFLOW_OUT), 0);
        chk("start_clears_sum", int'(SUM_OUT), 0);
        expect_run(127, 1);
        cyc(0, 1, 10, 1);
        chk("ovf_in_sub", int'(SUM_OUT), 127);
        cyc(0, 1, 20, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        drain();

        // restart mid-run drops same-cycle sample
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0); cyc(0, 1, 2, 0);
        expect_run(16, 0);
        cyc(1, 1, 50, 0);
        chk("restart_sum", int'(SUM_OUT), 0);
        cyc(0, 1, 4, 0); cyc(0, 1, 4, 0); cyc(0, 1, 4, 0); cyc(0, 1, 4, 0);
        drain();

        // IDLE sample ignored, gaps allowed
        cyc(0, 1, 9, 0);
        chk("idle_ignored", int'(SUM_OUT), 16);
        cyc(1, 0, 0, 0);
        expect_run(4, 0);
        cyc(0, 1, 1, 0); cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 0); cyc(0, 0, 0, 0);
        chk("busy_in_gap", int'(BUSY), 1);
        cyc(0, 1, 1, 0);
        drain();

        // exact MAXPOS boundary: no overflow
        cyc(1, 0, 0, 0);
        expect_run(127, 0);
        cyc(0, 1, 100, 0); cyc(0, 1, 27, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        drain();

        // negative input treated as MAXPOS
        cyc(1, 0, 0, 0);
        expect_run(127, 1);
        cyc(0, 1, 8'h90, 0);
        chk("neg_sub", int'(SUM_OUT), 127);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        drain();

        // async reset mid-run
        cyc(1, 0, 0, 0);
        cyc(0, 1, 6, 0); cyc(0, 1, 6, 0);
        #2 RSTN = 1'b0;
        #1;
        chk("arst_sum", int'(SUM_OUT), 0);
        chk("arst_ovf", int'(OVERFLOW_OUT), 0);
        chk("arst_busy", int'(BUSY), 0);
        chk("arst_valid", int'(VALID_OUT), 0);
        @(posedge CLK); #1;
        RSTN = 1'b1;
        for (int i = 0; i < 6; i++) cyc(0, 1, 5, 0);
        chk("no_start_sum", int'(SUM_OUT), 0);
        chk("no_start_busy", int'(BUSY), 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("pulse_count", n_pulse, n_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fixed_point_abs_accumulator.md
Name: fixed_point_abs_accumulator

Overview:
- Downstream consumer of the fixed-point absolute-value stage. Accumulates a fixed-length vector of absolute values into an L1-norm sum for the optimizer's distance and fitness computations.
- One run per START: counts VECTOR_LEN accepted samples, then presents a saturated sum with a sticky overflow flag.
- Input overflow (most-negative operand at the ABS stage) is absorbed as saturation rather than propagated as a wrong value.

Parameters:
- WIDTH, 8, data width of input samples and of the sum (signed two's complement).
- FRAC_BITS, 4, fractional bits. Informational only; the sum keeps the input's binary point.
- VECTOR_LEN, 4, number of samples per run (>=1).

Ports:
- CLK  input  1  clock, all state updated on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- START  input  1  single-cycle pulse: clear accumulator and begin a run.
- VALUE_IN  input  WIDTH  signed absolute value from the ABS stage.
- VALID_IN  input  1  VALUE_IN/OVERFLOW_IN qualifier.
- OVERFLOW_IN  input  1  ABS stage overflow for this sample.
- SUM_OUT  output  WIDTH  accumulated sum, non-negative, saturated.
- VALID_OUT  output  1  one-cycle pulse: SUM_OUT final for the run.
- OVERFLOW_OUT  output  1  sticky: any saturation or input overflow in the current run.
- BUSY  output  1  high while in ACCUM.

Behaviour:
- Reset: asynchronous, RSTN low clears all state. State=IDLE, count=0, SUM_OUT=0, VALID_OUT=0, OVERFLOW_OUT=0, BUSY=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - VALID_IN ignored.
  - START: sum<=0, count<=0, OVERFLOW_OUT<=0, go ACCUM.
- ACCUM:
  - Each cycle with VALID_IN=1, one sample is accepted and count increments.
  - Addend = VALUE_IN. If OVERFLOW_IN=1 or VALUE_IN[WIDTH-1]=1, addend is treated as MAXPOS (2^(WIDTH-1)-1) and OVERFLOW_OUT<=1.
  - Add uses a WIDTH+1-bit intermediate. If the result exceeds MAXPOS, sum<=MAXPOS and OVERFLOW_OUT<=1.
  - Once saturated, sum stays at MAXPOS for the rest of the run.
  - When the accepted sample has count==VECTOR_LEN-1: go DONE, VALID_OUT<=1 in the same edge. Latency is one cycle from the last VALID_IN to the VALID_OUT pulse, with SUM_OUT already including that sample.
- DONE:
  - VALID_OUT drops to 0 on the next cycle; state returns to IDLE.
  - SUM_OUT and OVERFLOW_OUT hold until the next START.
- START during ACCUM or DONE: restarts the run. Same-cycle VALID_IN is dropped, because START has priority. VALID_OUT is forced 0.
- VALID_IN gaps inside ACCUM are allowed; no timeout.
- VECTOR_LEN=1: a single accepted sample produces VALID_OUT on the next cycle.
- Count width: clog2(VECTOR_LEN), minimum 1. No wrap, since the run ends at VECTOR_LEN-1.
- BUSY = (state==ACCUM).

Optional Feature:
- Macro FIXED_POINT_ABS_ACC_MAX_EN.
- Defined:
  - Extra output MAX_OUT [WIDTH-1:0] holds the largest addend (after overflow substitution) seen in the current run.
  - START clears MAX_OUT to 0; RSTN resets it to 0.
  - MAX_OUT is updated on each accepted sample and is valid alongside VALID_OUT.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, VECTOR_LEN=4. START, then VALID_IN with 3,5,7,9 on consecutive cycles -> VALID_OUT pulses on the cycle after 9; SUM_OUT=24, OVERFLOW_OUT=0; BUSY low after that pulse.
- START, then samples 100,50,1,1 -> SUM_OUT=127 after the second sample and stays 127; OVERFLOW_OUT=1 at VALID_OUT.
- START, then 10, 20 with OVERFLOW_IN=1, 0, 0 -> SUM_OUT=127, OVERFLOW_OUT=1.
- START, samples 1,2, then START with VALID_IN=1 value 50, then 4,4,4,4 -> the 50 is dropped; SUM_OUT=16, one VALID_OUT pulse only.
- VALID_IN in IDLE with value 9, then START, then 1,1,1,1 with idle gaps between them -> SUM_OUT=4; the IDLE sample is ignored.
- Assert RSTN low mid-run after 2 samples -> all outputs 0 immediately. After release, VALID_IN without START -> no VALID_OUT.
